wb_stream_reader_cfg_mc: RTL

//  Multi-channel Wishbone slave configuration block for the stream reader DMA engines.

---
 rtl/wb_stream_cfg_pkg.sv | 38 +++
 rtl/wb_stream_cfg_chan.sv | 110 +++++++++++
 rtl/wb_stream_reader_cfg_mc.sv | 131 +++++++++++++
 3 files changed

// File: rtl/wb_stream_cfg_pkg.sv
// Register map, CTRL bit positions, ID word and address-decode helpers shared by the
// stream reader configuration block and its per-channel slice.
package wb_stream_cfg_pkg;

  // Channel page word offsets
  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_START_ADR  = 3'd1;
  localparam logic [2:0] REG_BUF_SIZE   = 3'd2;
  localparam logic [2:0] REG_BURST_SIZE = 3'd3;
  localparam logic [2:0] REG_TXCNT      = 3'd4;

  // Global page word offsets
  localparam logic [2:0] REG_IRQ_STAT   = 3'd0;
  localparam logic [2:0] REG_IRQ_MASK   = 3'd1;
  localparam logic [2:0] REG_BUSY       = 3'd2;
  localparam logic [2:0] REG_ID         = 3'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_CLR = 1;
  localparam int CTRL_CIRC    = 2;
  localparam int CTRL_OVR     = 3;

  localparam logic [23:0] ID_HI = {16'h5352, 8'h01};

  function automatic logic [31:0] id_word(input int nch);
    return {ID_HI, 8'(nch)};
  endfunction

  // Page 0 is the global page, page c+1 belongs to channel c
  function automatic logic [31:0] adr_page(input logic [31:0] adr);
    return {5'd0, adr[31:5]};
  endfunction

  function automatic logic [2:0] adr_word(input logic [31:0] adr);
    return adr[4:2];
  endfunction

endpackage

// File: rtl/wb_stream_cfg_chan.sv
// One stream reader channel: config registers, busy edge detect, start/overrun logic.
// Auto-restart on done is built only when WB_STREAM_CFG_AUTORESTART_EN is defined.
module wb_stream_cfg_chan
  import wb_stream_cfg_pkg::*;
#(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_i,
  input  logic [2:0]         word_i,
  input  logic [WB_DW-1:0]   dat_i,
  input  logic [WB_DW/8-1:0] sel_i,
  input  logic               busy_i,
  input  logic [WB_DW-1:0]   tx_cnt_i,
  input  logic               irq_stat_i,
  output logic [WB_DW-1:0]   rd_dat_o,
  output logic               enable_o,
  output logic               busy_r_o,
  output logic               done_o,
  output logic               irq_clr_o,
  output logic [WB_AW-1:0]   start_adr_o,
  output logic [WB_AW-1:0]   buf_size_o,
  output logic [WB_AW-1:0]   burst_size_o
);

  localparam int AWM = (WB_AW < WB_DW) ? WB_AW : WB_DW;
  localparam logic [WB_DW-1:0] BYTES_PER_WORD = WB_DW'(WB_DW / 8);

  logic [WB_AW-1:0] cfg_q [3];
  logic [WB_AW-1:0] cfg_d [3];
  logic             busy_q;
  logic             enable_q, enable_d;
  logic             ovr_q, ovr_d;
  logic             circ;
  logic             auto_restart;
  logic             ctrl_wr, start_req, done;

  assign ctrl_wr   = wr_i & (word_i == REG_CTRL) & sel_i[0];
  assign start_req = ctrl_wr & dat_i[CTRL_START];
  assign done      = busy_q & ~busy_i;

`ifdef WB_STREAM_CFG_AUTORESTART_EN
  logic circ_q, circ_d;

  assign circ_d       = ctrl_wr ? dat_i[CTRL_CIRC] : circ_q;
  assign circ         = circ_q;
  assign auto_restart = done & circ_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) circ_q <= 1'b0;
    else       circ_q <= circ_d;
  end
`else
  assign circ         = 1'b0;
  assign auto_restart = 1'b0;
`endif

  // A CPU start landing on an auto-restart merges into the same pulse, no overrun
  assign enable_d = (start_req & ~busy_q) | auto_restart;
  assign ovr_d    = (ovr_q & ~(ctrl_wr & dat_i[CTRL_OVR])) |
                    (start_req & busy_q & ~auto_restart);

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      cfg_d[r] = cfg_q[r];
      if (wr_i && word_i == 3'(r + 1)) begin
        for (int b = 0; b < AWM; b++) begin
          if (sel_i[b / 8]) cfg_d[r][b] = dat_i[b];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < 3; r++) cfg_q[r] <= '0;
      busy_q   <= 1'b0;
      enable_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      for (int r = 0; r < 3; r++) cfg_q[r] <= cfg_d[r];
      busy_q   <= busy_i;
      enable_q <= enable_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    rd_dat_o = '0;
    case (word_i)
      REG_CTRL:       rd_dat_o = WB_DW'({ovr_q, circ, irq_stat_i, busy_q});
      REG_START_ADR:  rd_dat_o = WB_DW'(cfg_q[0]);
      REG_BUF_SIZE:   rd_dat_o = WB_DW'(cfg_q[1]);
      REG_BURST_SIZE: rd_dat_o = WB_DW'(cfg_q[2]);
      REG_TXCNT:      rd_dat_o = tx_cnt_i * BYTES_PER_WORD;
      default:        rd_dat_o = '0;
    endcase
  end

  assign enable_o     = enable_q;
  assign busy_r_o     = busy_q;
  assign done_o       = done;
  assign irq_clr_o    = ctrl_wr & dat_i[CTRL_IRQ_CLR];
  assign start_adr_o  = cfg_q[0];
  assign buf_size_o   = cfg_q[1];
  assign burst_size_o = cfg_q[2];

endmodule

// File: rtl/wb_stream_reader_cfg_mc.sv
// Multi-channel Wishbone config slave for the stream reader DMA engines: ack, global
// IRQ registers, read mux and irq merge. Optional macro: WB_STREAM_CFG_AUTORESTART_EN.
module wb_stream_reader_cfg_mc
  import wb_stream_cfg_pkg::*;
#(
  parameter  int WB_AW = 32,
  parameter  int WB_DW = 32,
  parameter  int NCH   = 4,
  localparam int PG_W  = $clog2(NCH + 1)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [PG_W+4:0]      wb_adr_i,
  input  logic [WB_DW-1:0]     wb_dat_i,
  input  logic [WB_DW/8-1:0]   wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic [WB_DW-1:0]     wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 irq,
  input  logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       enable,
  input  logic [NCH*WB_DW-1:0] tx_cnt,
  output logic [NCH*WB_AW-1:0] start_adr,
  output logic [NCH*WB_AW-1:0] buf_size,
  output logic [NCH*WB_AW-1:0] burst_size
);

  logic             ack_q, ack_d;
  logic             irq_q, irq_d;
  logic [NCH-1:0]   irq_stat_q, irq_stat_d;
  logic [NCH-1:0]   irq_mask_q, irq_mask_d;
  logic [NCH-1:0]   busy_r, done, ctrl_clr, w1c, gmask;
  logic [WB_DW-1:0] chan_rd [NCH];
  logic [31:0]      page;
  logic [2:0]       word;
  logic             wr_en, glb_wr;
  logic             unused_ok;

  assign page   = adr_page(32'(wb_adr_i));
  assign word   = adr_word(32'(wb_adr_i));
  assign wr_en  = wb_cyc_i & wb_stb_i & wb_we_i & ack_q;
  assign glb_wr = wr_en & (page == 32'd0);
  assign ack_d  = wb_cyc_i & wb_stb_i & ~ack_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) gmask[i] = wb_sel_i[i / 8];
  end

  assign w1c = (glb_wr && word == REG_IRQ_STAT) ? (wb_dat_i[NCH-1:0] & gmask) : '0;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (glb_wr && word == REG_IRQ_MASK)
      irq_mask_d = (irq_mask_q & ~gmask) | (wb_dat_i[NCH-1:0] & gmask);
  end

  // A done event beats a clear arriving in the same cycle
  assign irq_stat_d = (irq_stat_q & ~(w1c | ctrl_clr)) | done;
  assign irq_d      = |(irq_stat_q & irq_mask_q);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
      irq_stat_q <= '0;
      irq_mask_q <= '0;
    end else begin
      ack_q      <= ack_d;
      irq_q      <= irq_d;
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic chan_wr;

    assign chan_wr = wr_en & (page == 32'(c + 1));

    wb_stream_cfg_chan #(
      .WB_AW (WB_AW),
      .WB_DW (WB_DW)
    ) u_chan (
      .clk_i        (wb_clk_i),
      .rst_i        (wb_rst_i),
      .wr_i         (chan_wr),
      .word_i       (word),
      .dat_i        (wb_dat_i),
      .sel_i        (wb_sel_i),
      .busy_i       (busy[c]),
      .tx_cnt_i     (tx_cnt[c*WB_DW +: WB_DW]),
      .irq_stat_i   (irq_stat_q[c]),
      .rd_dat_o     (chan_rd[c]),
      .enable_o     (enable[c]),
      .busy_r_o     (busy_r[c]),
      .done_o       (done[c]),
      .irq_clr_o    (ctrl_clr[c]),
      .start_adr_o  (start_adr[c*WB_AW +: WB_AW]),
      .buf_size_o   (buf_size[c*WB_AW +: WB_AW]),
      .burst_size_o (burst_size[c*WB_AW +: WB_AW])
    );
  end

  always_comb begin
    wb_dat_o = '0;
    if (page == 32'd0) begin
      case (word)
        REG_IRQ_STAT: wb_dat_o = WB_DW'(irq_stat_q);
        REG_IRQ_MASK: wb_dat_o = WB_DW'(irq_mask_q);
        REG_BUSY:     wb_dat_o = WB_DW'(busy_r);
        REG_ID:       wb_dat_o = WB_DW'(id_word(NCH));
        default:      wb_dat_o = '0;
      endcase
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (page == 32'(c + 1)) wb_dat_o = chan_rd[c];
      end
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = 1'b0;
  assign irq       = irq_q;
  assign unused_ok = ^{wb_cti_i, wb_bte_i};

endmodule
